seq_detect_cfg: RTL and testbench

- Serial-input pattern detector; generalises the fixed 8-bit detector.
- Adds parametrised pattern length, a runtime-loadable pattern and don't-care mask, input qualification, overlap or non-overlap mode, and a saturating match counter.
- Sits on a serial bitstream, such as a deserialiser or UART bit stream, ahead of framing or sync logic.

---
 rtl/seq_detect_cfg.sv | 65 ++++++
 tb/tb_seq_detect_cfg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_cfg.sv
// seq_detect_cfg: serial pattern detector with a loadable pattern and mask, overlap mode and a saturating match counter.
// Optional idle-gap history flush is enabled by defining SEQ_DET_GAP_EN.
module seq_detect_cfg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int GAP_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic             d_in,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  logic [WIDTH-1:0] pat, msk, hist, hist_n;
  logic [FW-1:0] fill, fill_n, fill_d;
  logic ovl, hit, gap_clr;
  always_comb begin
    hist_n = {hist[WIDTH-2:0], d_in};
    fill_n = (fill == FULL) ? FULL : fill + 1'b1;
    hit = d_valid && fill_n == FULL && ((hist_n ^ pat) & msk) == '0;
    fill_d = !d_valid ? (gap_clr ? '0 : fill) : (hit && !ovl) ? '0 : fill_n;
  end
  always_ff @(posedge clk)
    if (reset || cfg_load) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
      match_count <= '0;
      armed <= 1'b0;
      pat <= reset ? '1 : cfg_pattern;
      msk <= reset ? '1 : cfg_mask;
      ovl <= reset ? 1'b1 : cfg_overlap;
    end else begin
      hist <= d_valid ? hist_n : gap_clr ? '0 : hist;
      fill <= fill_d;
      match <= hit;
      armed <= fill_d == FULL;
      if (hit && match_count != '1) match_count <= match_count + 1'b1;
    end
`ifdef SEQ_DET_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] idle;
  logic idle_stop;
  assign gap_clr = !d_valid && !idle_stop && idle == GW'(GAP_CYCLES - 1);
  // after a flush the counter parks until the stream resumes
  always_ff @(posedge clk)
    if (reset || cfg_load || d_valid) begin
      idle <= '0;
      idle_stop <= 1'b0;
    end else if (!idle_stop) begin
      idle <= gap_clr ? '0 : idle + 1'b1;
      idle_stop <= gap_clr;
    end
`else
  assign gap_clr = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detect_cfg.sv
// tb_seq_detect_cfg: scoreboard bench for seq_detect_cfg; expected match pulses queued per driven cycle.
module tb_seq_detect_cfg;
  logic clk = 1'b0, reset = 1'b0, d_valid = 1'b0, d_in = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b1;
  logic [7:0] cfg_pattern = '1, cfg_mask = '1;
  logic match, armed, match2, armed2;
  logic [15:0] match_count;
  logic [1:0] count2;
  int vec = 0, fail = 0;
  logic exp_q[$];
  logic e;

  seq_detect_cfg #(.WIDTH(8), .CNT_W(16), .GAP_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_in(d_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .match(match), .match_count(match_count), .armed(armed));

  seq_detect_cfg #(.WIDTH(8), .CNT_W(2), .GAP_CYCLES(4)) u_sat (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_in(d_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .match(match2), .match_count(count2), .armed(armed2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (match !== e) begin
        fail++;
        $display("FAIL match at %0t: got %b expected %b", $time, match, e);
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic ld, input logic ex);
    d_valid = v; d_in = b; cfg_load = ld;
    exp_q.push_back(ex);
    @(posedge clk); #1;
    d_valid = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] m, input logic o);
    cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input logic [15:0] hits, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, hits[i]);
      for (int k = 0; k < gap; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    vec++; if (match_count !== 16'd0) begin fail++; $display("FAIL reset_count: got %0d expected 0", match_count); end
    vec++; if (armed !== 1'b0) begin fail++; $display("FAIL reset_armed: got %b expected 0", armed); end
    vec++; if (count2 !== 2'd0) begin fail++; $display("FAIL reset_count2: got %0d expected 0", count2); end
    feed(16'h00FF, 8, 16'h0001, 0);
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL reset_default_pattern: got %0d expected 1", match_count); end
  endtask

  task automatic test_overlap;
    load(8'h55, 8'hFF, 1'b1);
    feed(16'h002A, 7, 16'h0000, 0);
    vec++; if (armed !== 1'b0) begin fail++; $display("FAIL armed_7bits: got %b expected 0", armed); end
    feed(16'h0001, 1, 16'h0001, 0);
    vec++; if (armed !== 1'b1) begin fail++; $display("FAIL armed_8bits: got %b expected 1", armed); end
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL overlap_first: got %0d expected 1", match_count); end
    feed(16'h0001, 2, 16'h0001, 0);
    vec++; if (match_count !== 16'd2) begin fail++; $display("FAIL overlap_second: got %0d expected 2", match_count); end
  endtask

  task automatic test_nonoverlap;
    load(8'h55, 8'hFF, 1'b0);
    feed(16'h0555, 12, 16'h0010, 0);
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL nonoverlap_count: got %0d expected 1", match_count); end
    vec++; if (armed !== 1'b0) begin fail++; $display("FAIL nonoverlap_armed: got %b expected 0", armed); end
  endtask

  task automatic test_mask;
    load(8'hA5, 8'hF0, 1'b1);
    feed(16'h00AF, 8, 16'h0001, 0);
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL mask_partial: got %0d expected 1", match_count); end
    load(8'hA5, 8'hFF, 1'b1);
    feed(16'h00AF, 8, 16'h0000, 0);
    vec++; if (match_count !== 16'd0) begin fail++; $display("FAIL mask_full: got %0d expected 0", match_count); end
  endtask

  task automatic test_idle_and_load;
    load(8'h55, 8'hFF, 1'b1);
    feed(16'h0055, 8, 16'h0001, 3);
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL interleaved: got %0d expected 1", match_count); end
    load(8'h55, 8'hFF, 1'b1);
    feed(16'h002A, 7, 16'h0000, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    vec++; if (armed !== 1'b0) begin fail++; $display("FAIL load_collision_armed: got %b expected 0", armed); end
    vec++; if (match_count !== 16'd0) begin fail++; $display("FAIL load_collision_count: got %0d expected 0", match_count); end
  endtask

  task automatic test_reset_mid;
    load(8'h55, 8'hFF, 1'b1);
    feed(16'h002A, 7, 16'h0000, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    vec++; if (match_count !== 16'd0) begin fail++; $display("FAIL reset_mid_count: got %0d expected 0", match_count); end
    vec++; if (armed !== 1'b0) begin fail++; $display("FAIL reset_mid_armed: got %b expected 0", armed); end
  endtask

  task automatic test_saturation;
    load(8'h00, 8'h00, 1'b1);
    feed(16'h0000, 12, 16'h001F, 0);
    vec++; if (match_count !== 16'd5) begin fail++; $display("FAIL sat_wide: got %0d expected 5", match_count); end
    vec++; if (count2 !== 2'd3) begin fail++; $display("FAIL sat_narrow: got %0d expected 3", count2); end
    load(8'h00, 8'h00, 1'b0);
    feed(16'h0000, 16, 16'h0101, 0);
    vec++; if (match_count !== 16'd2) begin fail++; $display("FAIL mask0_nonoverlap: got %0d expected 2", match_count); end
  endtask

  task automatic test_gap;
    load(8'hA5, 8'hFF, 1'b1);
    feed(16'h000A, 4, 16'h0000, 0);
    idle(4);
`ifdef SEQ_DET_GAP_EN
    feed(16'h0005, 4, 16'h0000, 0);
    vec++; if (match_count !== 16'd0) begin fail++; $display("FAIL gap_flush: got %0d expected 0", match_count); end
`else
    feed(16'h0005, 4, 16'h0001, 0);
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL gap_retain: got %0d expected 1", match_count); end
`endif
    load(8'hA5, 8'hFF, 1'b1);
    feed(16'h000A, 4, 16'h0000, 0);
    idle(3);
    feed(16'h0005, 4, 16'h0001, 0);
    vec++; if (match_count !== 16'd1) begin fail++; $display("FAIL gap_short: got %0d expected 1", match_count); end
  endtask

  initial begin
    test_reset;
    test_overlap;
    test_nonoverlap;
    test_mask;
    test_idle_and_load;
    test_reset_mid;
    test_saturation;
    test_gap;
    idle(2);
    @(posedge clk); #2;
    vec++; if (exp_q.size() != 0) begin fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end
endmodule
